// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared width default, access-size encodings and FSM states
package load_store_unit_pkg;
  localparam int LSU_XLEN = 32;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response and data-memory bus of the load/store unit
interface load_store_unit_if import load_store_unit_pkg::*; #(
  parameter int XLEN = LSU_XLEN
);
  localparam int NB = XLEN / 8;
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [1:0]      req_size;
  logic            req_uext;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            except;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [NB-1:0]   bus_wmask;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  modport master (
    output req_valid, req_store, req_size, req_uext, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, except, bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );
  modport slave (
    input  req_valid, req_store, req_size, req_uext, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_rdata, except, bus_req, bus_we, bus_addr, bus_wdata, bus_wmask
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// lsu_extend: truncates load data to byte/half/word/dword and sign- or zero-extends to XLEN
module lsu_extend import load_store_unit_pkg::*; #(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_uext,
  output logic [XLEN-1:0] o_data
);
  logic [XLEN-1:0] w_keep;
  logic            w_sign;
  always_comb begin
    w_keep = i_size == SIZE_B ? XLEN'(8'hFF) : i_size == SIZE_H ? XLEN'(16'hFFFF) :
             i_size == SIZE_W ? XLEN'(32'hFFFF_FFFF) : '1;
    w_sign = !i_uext && (i_size == SIZE_B ? i_data[7] : i_size == SIZE_H ? i_data[15] :
             i_size == SIZE_W ? i_data[31] : i_data[XLEN-1]);
    o_data = (i_data & w_keep) | (w_sign ? ~w_keep : '0);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked load/store unit, splitting boundary-crossing accesses into two bus beats
module load_store_unit import load_store_unit_pkg::*; #(
  parameter int XLEN             = LSU_XLEN,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave lsu
);
  localparam int NB = XLEN / 8;
  localparam int NW = 2 * NB;
  localparam int DW = 2 * XLEN;
  localparam int OW = $clog2(NB);
  logic [1:0]      r_state;
  logic            r_store;
  logic            r_uext;
  logic            r_cross;
  logic            r_exc;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [DW-1:0]   r_buf;
  logic [OW-1:0]   w_req_off;
  logic [OW-1:0]   w_off;
  logic [3:0]      w_req_bytes;
  logic [3:0]      w_bytes;
  logic            w_req_cross;
  logic            w_req_bad;
  logic            w_beat;
  logic            w_store_beat;
  logic [NW-1:0]   w_mwin;
  logic [DW-1:0]   w_dsh;
  logic [DW-1:0]   w_dwin;
  logic [XLEN-1:0] w_ld;
  logic [XLEN-1:0] w_ext;
  assign w_req_off   = lsu.req_addr[OW-1:0];
  assign w_req_bytes = 4'd1 << lsu.req_size;
  assign w_req_cross = (int'(w_req_off) + int'(w_req_bytes)) > NB;
  assign w_req_bad   = (XLEN == 32 && lsu.req_size == SIZE_D) || (w_req_cross && !ALLOW_MISALIGNED);
  // Store data and mask are laid out over a two-word window; beat0 drives the low word, beat1 the high.
  assign w_off   = r_addr[OW-1:0];
  assign w_bytes = 4'd1 << r_size;
  assign w_mwin  = ((NW'(1) << w_bytes) - NW'(1)) << w_off;
  assign w_dsh   = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  for (genvar g = 0; g < NW; g++) begin : g_lane
    assign w_dwin[8*g +: 8] = w_mwin[g] ? w_dsh[8*g +: 8] : 8'h00;
  end
  assign w_beat         = r_state == ST_BEAT1;
  assign lsu.bus_req    = r_state == ST_BEAT0 || w_beat;
  assign w_store_beat   = lsu.bus_req && r_store;
  assign lsu.bus_we     = w_store_beat;
  assign lsu.bus_addr   = lsu.bus_req ? {r_addr[XLEN-1:OW], OW'(0)} + (w_beat ? XLEN'(NB) : '0) : '0;
  assign lsu.bus_wmask  = w_store_beat ? (w_beat ? w_mwin[NW-1:NB] : w_mwin[NB-1:0]) : '0;
  assign lsu.bus_wdata  = w_store_beat ? (w_beat ? w_dwin[DW-1:XLEN] : w_dwin[XLEN-1:0]) : '0;
  assign lsu.req_ready  = r_state == ST_IDLE;
  assign lsu.resp_valid = r_state == ST_RESP;
  assign lsu.except     = lsu.resp_valid && r_exc;
  assign w_ld           = XLEN'(r_buf >> {w_off, 3'b000});
  assign lsu.resp_rdata = lsu.resp_valid && !r_store && !r_exc ? w_ext : '0;
  lsu_extend #(.XLEN(XLEN)) u_ext (
    .i_data(w_ld),
    .i_size(r_size),
    .i_uext(r_uext),
    .o_data(w_ext)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_store <= 1'b0;
      r_uext  <= 1'b0;
      r_cross <= 1'b0;
      r_exc   <= 1'b0;
      r_size  <= SIZE_B;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (lsu.req_valid) begin
          r_store <= lsu.req_store;
          r_uext  <= lsu.req_uext;
          r_size  <= lsu.req_size;
          r_addr  <= lsu.req_addr;
          r_wdata <= lsu.req_wdata;
          r_cross <= w_req_cross;
          r_exc   <= w_req_bad;
          r_buf   <= '0;
          r_state <= w_req_bad ? ST_RESP : ST_BEAT0;
        end
        ST_BEAT0: if (lsu.bus_ack) begin
          r_buf[XLEN-1:0] <= lsu.bus_rdata;
          r_state         <= r_cross ? ST_BEAT1 : ST_RESP;
        end
        ST_BEAT1: if (lsu.bus_ack) begin
          r_buf[DW-1:XLEN] <= lsu.bus_rdata;
          r_state          <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
